// File: rtl/skewed_acc_bank_pkg.sv
// -----------------------------------------------------------------------------
// skewed_acc_bank_pkg
//   Shared types and helpers for the skewed accumulator bank.
//   - state_e : drain FSM states (ACCUM, WAIT_SKEW, DRAIN)
//   - ctrl_t  : per-beat control token {valid, init, done, row}. It travels
//               down the lane chain one register per lane.
//   - sat_e   : overflow classification of an accumulate
//   - acc_add : classifies a wrapped two's-complement accumulate. When
//               ACC_SATURATE_EN is defined it flags positive/negative
//               overflow so the lane can clamp. Otherwise it always reports
//               SAT_NONE, which gives a plain wrapping add.
//   Configuration macro: ACC_SATURATE_EN (saturating accumulate).
// -----------------------------------------------------------------------------
package skewed_acc_bank_pkg;

  // Width of the row field carried in the token. This covers ACC_DEPTH up to 256.
  localparam int ROW_FIELD_W = 8;

  typedef enum logic [1:0] {
    ACCUM,
    WAIT_SKEW,
    DRAIN
  } state_e;

  typedef struct packed {
    logic                   valid;
    logic                   init;
    logic                   done;
    logic [ROW_FIELD_W-1:0] row;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  typedef enum logic [1:0] {
    SAT_NONE,
    SAT_POS,
    SAT_NEG
  } sat_e;

  // The sign bits of both operands and of the wrapped sum are enough to
  // detect signed overflow, so the helper is independent of DATA_WIDTH.
  function automatic sat_e acc_add(input logic acc_msb,
                                   input logic data_msb,
                                   input logic sum_msb);
`ifdef ACC_SATURATE_EN
    if (!acc_msb && !data_msb && sum_msb) return SAT_POS;
    if (acc_msb && data_msb && !sum_msb) return SAT_NEG;
    return SAT_NONE;
`else
    return (acc_msb & data_msb & sum_msb & 1'b0) ? SAT_POS : SAT_NONE;
`endif
  endfunction

endpackage

// File: rtl/skewed_acc_lane.sv
// -----------------------------------------------------------------------------
// skewed_acc_lane
//   One column of the accumulator bank. The lane writes acc[tok.row] in the
//   same cycle its incoming token is valid. An init token overwrites the
//   entry; any other token accumulates into it. The token is then registered
//   so that the next lane sees it one cycle later.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset (token only)
//     tok_i      : control token for this lane (ctrl_t, flattened)
//     data_i     : this lane's skewed input data
//     rd_row_i   : drain read row
//     tok_o      : token registered for the next lane
//     rd_data_o  : acc[rd_row_i]
//   Configuration macro: ACC_SATURATE_EN (via skewed_acc_bank_pkg::acc_add).
// -----------------------------------------------------------------------------
module skewed_acc_lane
  import skewed_acc_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_DEPTH  = 16,
  parameter int ROW_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CTRL_W-1:0]     tok_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [ROW_W-1:0]      rd_row_i,
  output logic [CTRL_W-1:0]     tok_o,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  ctrl_t                 tok;
  ctrl_t                 tok_q;
  logic [DATA_WIDTH-1:0] acc_q [ACC_DEPTH];
  logic [DATA_WIDTH-1:0] cur;
  logic [DATA_WIDTH-1:0] raw_sum;
  logic [DATA_WIDTH-1:0] wr_data;

  assign tok = ctrl_t'(tok_i);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cur = '0;
    for (int r = 0; r < ACC_DEPTH; r++) begin
      if (tok.row == ROW_FIELD_W'(r)) cur = acc_q[r];
    end
  end

  assign raw_sum = cur + data_i;

  always_comb begin
    wr_data = raw_sum;
    if (tok.init) begin
      wr_data = data_i;
    end else begin
      case (acc_add(cur[DATA_WIDTH-1], data_i[DATA_WIDTH-1], raw_sum[DATA_WIDTH-1]))
        SAT_POS: wr_data = SAT_MAX;
        SAT_NEG: wr_data = SAT_MIN;
        default: wr_data = raw_sum;
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples pre-edge values regardless of process order.
  always_ff @(posedge clk) begin
    if (rst) tok_q <= '0;
    else     tok_q <= tok;
  end

  // NOTE: the accumulator array is deliberately not reset. Its contents are
  // only meaningful after an init pass, and clearing it would add a reset
  // path to every storage bit.
  // Tokens still in flight while rst is high are dropped, not written.
  always_ff @(posedge clk) begin
    for (int r = 0; r < ACC_DEPTH; r++) begin
      if (!rst && tok.valid && tok.row == ROW_FIELD_W'(r)) acc_q[r] <= wr_data;
    end
  end

  assign tok_o     = tok_q;
  assign rd_data_o = acc_q[rd_row_i];

endmodule

// File: rtl/skewed_acc_bank.sv
// -----------------------------------------------------------------------------
// skewed_acc_bank
//   Accumulates skewed systolic-array column results over several K-passes.
//   After the final pass, it drains ACC_DEPTH rows (or fewer) lane-aligned
//   through a valid/ready port.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     in_data_i       : LANES x DATA_WIDTH. Lane i carries beat t at cycle t+i
//     in_valid_i      : beat valid (lane-0 timing)
//     in_ready_o      : bank accepts beats (low while rst or not ACCUM)
//     is_init_data_i  : beat belongs to the first pass (overwrite)
//     calc_done_i     : beat belongs to the final pass (drain afterwards)
//     cfg_depth_i     : rows per pass; 0 or >ACC_DEPTH means ACC_DEPTH
//     out_data_o      : aligned row, zero when out_valid_o is low
//     out_valid_o     : row valid
//     out_ready_i     : downstream accepts row
//     busy_o          : token in flight, pass open, or drain under way
//   Configuration macro: ACC_SATURATE_EN (saturating accumulate).
// -----------------------------------------------------------------------------
module skewed_acc_bank
  import skewed_acc_bank_pkg::*;
#(
  parameter  int LANES      = 16,
  parameter  int DATA_WIDTH = 32,
  parameter  int ACC_DEPTH  = 16,
  localparam int DW_DEPTH   = $clog2(ACC_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LANES*DATA_WIDTH-1:0] in_data_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic                        is_init_data_i,
  input  logic                        calc_done_i,
  input  logic [DW_DEPTH-1:0]         cfg_depth_i,
  output logic [LANES*DATA_WIDTH-1:0] out_data_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic                        busy_o
);

  localparam int                  ROW_W     = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;
  localparam logic [DW_DEPTH-1:0] DEPTH_MAX = DW_DEPTH'(ACC_DEPTH);

  state_e                      state_q, state_d;
  logic [ROW_W-1:0]            row_q, row_d;
  logic [ROW_W-1:0]            drow_q, drow_d;
  logic [DW_DEPTH-1:0]         depth_q, depth_d;
  logic [DW_DEPTH-1:0]         cfg_depth_eff;
  logic [DW_DEPTH-1:0]         cur_depth;
  logic                        accept;
  logic                        last_row;
  logic                        skew_last;
  logic                        tok_busy;
  ctrl_t                       chain [LANES+1];
  logic [LANES*DATA_WIDTH-1:0] rd_row;

  assign in_ready_o = !rst && (state_q == ACCUM);
  assign accept     = in_valid_i && in_ready_o;

  assign cfg_depth_eff = (cfg_depth_i == '0 || cfg_depth_i > DEPTH_MAX) ? DEPTH_MAX : cfg_depth_i;
  // Row 0 opens a pass, so the freshly configured depth applies to that beat.
  assign cur_depth     = (row_q == '0) ? cfg_depth_eff : depth_q;
  assign last_row      = (DW_DEPTH'(row_q) == cur_depth - DW_DEPTH'(1));

  // Token entering lane 0 in the accept cycle.
  always_comb begin
    chain[0] = '0;
    if (accept) begin
      chain[0].valid = 1'b1;
      chain[0].init  = is_init_data_i;
      chain[0].done  = calc_done_i;
      chain[0].row   = ROW_FIELD_W'(row_q);
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    skewed_acc_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_DEPTH  (ACC_DEPTH),
      .ROW_W      (ROW_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .tok_i     (chain[i]),
      .data_i    (in_data_i[i*DATA_WIDTH +: DATA_WIDTH]),
      .rd_row_i  (drow_q),
      .tok_o     (chain[i+1]),
      .rd_data_o (rd_row[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // The last lane is writing the final row of the done pass this cycle. From
  // the next cycle on, every lane holds the complete tile.
  assign skew_last = chain[LANES-1].valid && chain[LANES-1].done &&
                     (chain[LANES-1].row == ROW_FIELD_W'(depth_q - DW_DEPTH'(1)));

  always_comb begin
    tok_busy = 1'b0;
    for (int k = 1; k <= LANES; k++) begin
      if (chain[k].valid) tok_busy = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    drow_d  = drow_q;
    depth_d = depth_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (row_q == '0) depth_d = cfg_depth_eff;
          if (last_row) begin
            row_d = '0;
            if (calc_done_i) state_d = (LANES == 1) ? DRAIN : WAIT_SKEW;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      WAIT_SKEW: begin
        if (skew_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_ready_i) begin
          if (DW_DEPTH'(drow_q) == depth_q - DW_DEPTH'(1)) begin
            drow_d  = '0;
            state_d = ACCUM;
          end else begin
            drow_d = drow_q + ROW_W'(1);
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      row_q   <= '0;
      drow_q  <= '0;
      depth_q <= DEPTH_MAX;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      drow_q  <= drow_d;
      depth_q <= depth_d;
    end
  end

  assign out_valid_o = (state_q == DRAIN);
  assign out_data_o  = out_valid_o ? rd_row : '0;
  assign busy_o      = tok_busy || (row_q != '0) || (state_q != ACCUM);

endmodule

// File: tb/tb_skewed_acc_bank.sv
module tb_skewed_acc_bank;
  localparam int LANES = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int DWD   = 3;
  localparam int ROWB  = LANES * DW;

  logic            clk = 1'b0;
  logic            rst;
  logic [ROWB-1:0] in_data_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic            is_init_data_i;
  logic            calc_done_i;
  logic [DWD-1:0]  cfg_depth_i;
  logic [ROWB-1:0] out_data_o;
  logic            out_valid_o;
  logic            out_ready_i;
  logic            busy_o;

  always #5 clk = ~clk;

  skewed_acc_bank #(
    .LANES      (LANES),
    .DATA_WIDTH (DW),
    .ACC_DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_data_i      (in_data_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .is_init_data_i (is_init_data_i),
    .calc_done_i    (calc_done_i),
    .cfg_depth_i    (cfg_depth_i),
    .out_data_o     (out_data_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .busy_o         (busy_o)
  );

  // Skew generator: lane i shows the beat that was accepted i cycles earlier.
  logic [LANES-1:0][DW-1:0] cur_beat;
  logic [LANES-1:0][DW-1:0] hist [1:LANES-1];

  always @(posedge clk) begin
    hist[1] <= (in_valid_i && in_ready_o) ? cur_beat : '0;
    for (int k = 2; k < LANES; k++) hist[k] <= hist[k-1];
  end

  always_comb begin
    in_data_i = '0;
    in_data_i[0 +: DW] = cur_beat[0];
    for (int i = 1; i < LANES; i++) in_data_i[i*DW +: DW] = hist[i][i];
  end

  // Reference model and scoreboard.
  logic [DW-1:0]   m [LANES][DEPTH];
  logic [ROWB-1:0] exp_q [$];
  int              n_pass = 0;
  int              n_total = 0;
  int              n_hs = 0;
  logic            mon_en = 1'b0;

  function automatic logic [DW-1:0] model_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
`ifdef ACC_SATURATE_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    return DW'(s);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic send_beat(input logic [LANES-1:0][DW-1:0] vals, input logic init,
                           input logic done, input logic [DWD-1:0] cfg,
                           input int row, input int eff_depth);
    int waited;
    logic [ROWB-1:0] e;
    waited = 0;
    @(negedge clk);
    cur_beat       = vals;
    in_valid_i     = 1'b1;
    is_init_data_i = init;
    calc_done_i    = done;
    cfg_depth_i    = cfg;
    while (!in_ready_o && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready_o) check("accept_timeout", 64'(in_ready_o), 64'd1);
    for (int i = 0; i < LANES; i++)
      m[i][row] = init ? vals[i] : model_add(m[i][row], vals[i]);
    if (done && row == eff_depth - 1) begin
      for (int r = 0; r < eff_depth; r++) begin
        for (int i = 0; i < LANES; i++) e[i*DW +: DW] = m[i][r];
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
  endtask

  task automatic end_beats();
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid_o && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (!out_valid_o) check("valid_timeout", 64'(out_valid_o), 64'd1);
  endtask

  // Returns in the cycle of the final handshake, sampled after the monitor.
  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      if (out_valid_o && out_ready_i) begin
        n_hs++;
        if (exp_q.size() == 0) check("unexpected_row", 64'(out_valid_o), 64'd0);
        else check("drain_row", out_data_o, exp_q.pop_front());
      end else if (!out_valid_o) begin
        check("idle_zero", out_data_o, 64'd0);
      end
    end
  end

  initial begin
    logic [LANES-1:0][DW-1:0] v;
    int hs0;
    rst = 1'b1; in_valid_i = 1'b0; is_init_data_i = 1'b0; calc_done_i = 1'b0;
    cfg_depth_i = '0; out_ready_i = 1'b1; cur_beat = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check("rst_in_ready", 64'(in_ready_o), 64'd0);
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_out_data", out_data_o, 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    #2;
    check("post_rst_ready", 64'(in_ready_o), 64'd1);
    mon_en = 1'b1;

    // 1: single pass, depth 2, data 10*i+r
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < LANES; i++) v[i] = DW'(10 * i + r);
      send_beat(v, 1'b1, 1'b1, 3'd2, r, 2);
    end
    end_beats();
    #2;
    check("t1_ready_low", 64'(in_ready_o), 64'd0);
    check("t1_busy", 64'(busy_o), 64'd1);
    check("t1_skew_c1", 64'(out_valid_o), 64'd0);
    @(negedge clk); #2;
    check("t1_skew_c2", 64'(out_valid_o), 64'd0);
    @(negedge clk); #2;
    check("t1_skew_c3", 64'(out_valid_o), 64'd0);
    @(negedge clk); #2;
    check("t1_drain_start", 64'(out_valid_o), 64'd1);
    wait_drain();
    check("t1_ready_last_hs", 64'(in_ready_o), 64'd0);
    @(negedge clk); #2;
    check("t1_ready_back", 64'(in_ready_o), 64'd1);
    check("t1_valid_off", 64'(out_valid_o), 64'd0);
    check("t1_idle", 64'(busy_o), 64'd0);

    // 2: three passes of depth 4: 1 + 2 + 3 = 6 everywhere
    for (int p = 0; p < 3; p++) begin
      for (int r = 0; r < 4; r++) begin
        for (int i = 0; i < LANES; i++) v[i] = DW'(p + 1);
        send_beat(v, p == 0, p == 2, 3'd4, r, 4);
      end
      if (p == 0) begin
        end_beats();
        #2;
        check("t2_ready_mid", 64'(in_ready_o), 64'd1);
        check("t2_busy_mid", 64'(busy_o), 64'd1);
      end
    end
    end_beats();
    wait_drain();

    // 3: backpressure on row 0
    @(negedge clk);
    out_ready_i = 1'b0;
    hs0 = n_hs;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < LANES; i++) v[i] = DW'(100 + 10 * i + r);
      send_beat(v, 1'b1, 1'b1, 3'd4, r, 4);
    end
    end_beats();
    wait_valid();
    for (int c = 0; c < 5; c++) begin
      check("t3_hold_valid", 64'(out_valid_o), 64'd1);
      check("t3_hold_data", out_data_o, exp_q[0]);
      @(negedge clk); #2;
    end
    @(negedge clk);
    out_ready_i = 1'b1;
    wait_drain();
    repeat (3) @(negedge clk);
    check("t3_rows", 64'(n_hs - hs0), 64'd4);

    // 4: overflow behaviour
    for (int i = 0; i < LANES; i++) v[i] = 16'h7FFF;
    send_beat(v, 1'b1, 1'b0, 3'd2, 0, 2);
    for (int i = 0; i < LANES; i++) v[i] = 16'h8000;
    send_beat(v, 1'b1, 1'b0, 3'd2, 1, 2);
    for (int i = 0; i < LANES; i++) v[i] = 16'h0001;
    send_beat(v, 1'b0, 1'b1, 3'd2, 0, 2);
    for (int i = 0; i < LANES; i++) v[i] = 16'hFFFF;
    send_beat(v, 1'b0, 1'b1, 3'd2, 1, 2);
    end_beats();
    wait_drain();

    // 5: reset in the middle of a drain
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < LANES; i++) v[i] = DW'(7 + i + r);
      send_beat(v, 1'b1, 1'b1, 3'd4, r, 4);
    end
    end_beats();
    begin
      int n;
      n = 0;
      while (exp_q.size() > 2 && n < 50) begin
        @(negedge clk); #2;
        n++;
      end
    end
    check("t5_two_rows_out", 64'(exp_q.size()), 64'd2);
    @(negedge clk);
    rst = 1'b1;
    out_ready_i = 1'b0;
    #2;
    check("t5_valid_before_edge", 64'(out_valid_o), 64'd1);
    @(negedge clk); #2;
    check("t5_valid_dropped", 64'(out_valid_o), 64'd0);
    check("t5_ready_in_rst", 64'(in_ready_o), 64'd0);
    check("t5_busy_cleared", 64'(busy_o), 64'd0);
    exp_q.delete();
    rst = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk); #2;
    check("t5_ready_after", 64'(in_ready_o), 64'd1);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < LANES; i++) v[i] = DW'(200 + 16 * i + r);
      send_beat(v, 1'b1, 1'b1, 3'd2, r, 2);
    end
    end_beats();
    wait_drain();

    // 6: cfg_depth_i = 0 means full depth; input noise during drain
    @(negedge clk);
    out_ready_i = 1'b0;
    hs0 = n_hs;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < LANES; i++) v[i] = DW'(3 * i + r + 1);
      send_beat(v, 1'b1, 1'b1, 3'd0, r, 4);
    end
    end_beats();
    wait_valid();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid_i     = ~in_valid_i;
      cur_beat       = {$urandom, $urandom};
      is_init_data_i = 1'b1;
      calc_done_i    = 1'b1;
      cfg_depth_i    = 3'd1;
      #2;
      check("t6_ready_low", 64'(in_ready_o), 64'd0);
      check("t6_hold_data", out_data_o, exp_q[0]);
    end
    @(negedge clk);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    wait_drain();
    repeat (3) @(negedge clk);
    check("t6_rows", 64'(n_hs - hs0), 64'd4);
    check("t6_idle", 64'(busy_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
